// File: rtl/baud_cfg_ctrl.sv
// Run-time baud-code change controller: accepts a host request, drains the link,
// restarts baud_gen with the new code, waits a settle interval and reports done/err.
module baud_cfg_ctrl #(
  parameter logic [3:0]  DEFAULT_CODE   = 4'b0100,
  parameter int unsigned GEN_RST_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_code,
  output logic       cfg_ready,
  input  logic       tx_busy,
  input  logic       rx_busy,
  output logic [3:0] baud_rate,
  output logic       gen_reset_n,
  output logic       tx_hold,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [1:0] err_cause
);

  localparam int unsigned MAX_A   = (GEN_RST_CYCLES > SETTLE_CYCLES) ? GEN_RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] GRST_LAST    = CW'(GEN_RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    CODE_MIN     = 4'b0100;
  localparam logic [3:0]    CODE_MAX     = 4'b1000;

  typedef enum logic [2:0] {IDLE, DRAIN, GRST, SETTLE, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    pend, pend_nxt, baud_nxt;
  logic          grst_nxt, hold_nxt, done_nxt, err_nxt;
  logic [1:0]    cause_nxt;

  assign cfg_ready = (state == IDLE) & ~reset;
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    baud_nxt  = baud_rate;
    grst_nxt  = 1'b1;
    hold_nxt  = tx_hold;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    cause_nxt = err_cause;
    unique case (state)
      IDLE: begin
        if (cfg_valid) begin
          pend_nxt  = cfg_code;
          cause_nxt = 2'b00;
          if ((cfg_code < CODE_MIN) || (cfg_code > CODE_MAX)) begin
            err_nxt   = 1'b1;
            cause_nxt = 2'b01;
          end else if (cfg_code == baud_rate) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = DRAIN;
            hold_nxt  = 1'b1;
            cnt_nxt   = '0;
          end
        end
      end
      DRAIN: begin
        if (!tx_busy && !rx_busy) begin
          state_nxt = GRST;
          baud_nxt  = pend;
          grst_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          cause_nxt = 2'b10;
          hold_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      GRST: begin
        // gen_reset_n stays low until the edge that ends the last GRST cycle
        if (cnt == GRST_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else begin
          grst_nxt = 1'b0;
          cnt_nxt  = cnt_inc;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          hold_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pend        <= '0;
      baud_rate   <= DEFAULT_CODE;
      gen_reset_n <= 1'b0;
      tx_hold     <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      err_cause   <= 2'b00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pend        <= pend_nxt;
      baud_rate   <= baud_nxt;
      gen_reset_n <= grst_nxt;
      tx_hold     <= hold_nxt;
      cfg_done    <= done_nxt;
      cfg_err     <= err_nxt;
      err_cause   <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Scoreboard bench for baud_cfg_ctrl: per-cycle expected output vectors are queued with
// the stimulus and compared one clock later, 1 time unit after the rising edge.
module tb_baud_cfg_ctrl;

  localparam logic [3:0]  DEF  = 4'b0100;
  localparam int unsigned NRST = 2;
  localparam int unsigned NSET = 16;
  localparam int unsigned NTO  = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_code = 4'b0000;
  logic       tx_busy = 1'b0;
  logic       rx_busy = 1'b0;
  logic       cfg_ready, gen_reset_n, tx_hold, cfg_done, cfg_err;
  logic [3:0] baud_rate;
  logic [1:0] err_cause;

  string       tag_q[$];
  logic [10:0] exp_q[$];
  string       cur_tag = "reset";
  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  baud_cfg_ctrl #(
    .DEFAULT_CODE  (DEF),
    .GEN_RST_CYCLES(NRST),
    .SETTLE_CYCLES (NSET),
    .TIMEOUT_CYCLES(NTO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_code   (cfg_code),
    .cfg_ready  (cfg_ready),
    .tx_busy    (tx_busy),
    .rx_busy    (rx_busy),
    .baud_rate  (baud_rate),
    .gen_reset_n(gen_reset_n),
    .tx_hold    (tx_hold),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .err_cause  (err_cause)
  );

  // Vector layout: {baud_rate, gen_reset_n, tx_hold, cfg_done, cfg_err, err_cause, cfg_ready}
  function automatic logic [10:0] mk(input logic [3:0] b, input logic g, input logic h,
                                     input logic d, input logic e, input logic [1:0] c,
                                     input logic r);
    return {b, g, h, d, e, c, r};
  endfunction

  task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %b expected %b (baud,grst_n,hold,done,err,cause,ready)",
               tag, $time, got, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic vld, input logic [3:0] code,
                     input logic txb, input logic rxb, input logic [10:0] v);
    @(negedge clk);
    reset     = rst;
    cfg_valid = vld;
    cfg_code  = code;
    tx_busy   = txb;
    rx_busy   = rxb;
    tag_q.push_back(cur_tag);
    exp_q.push_back(v);
  endtask

  task automatic idle(input logic [3:0] b, input logic [1:0] c);
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, mk(b, 1'b1, 1'b0, 1'b0, 1'b0, c, 1'b1));
  endtask

  // Full change sequence; tx_busy high at the acceptance edge and nbusy-1 edges after it.
  task automatic change(input logic [3:0] old, input logic [3:0] nw, input int unsigned nbusy);
    cyc(1'b0, 1'b1, nw, (nbusy > 0), 1'b0, mk(old, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    for (int unsigned i = 1; i < nbusy; i++)
      cyc(1'b0, 1'b1, 4'b0111, 1'b1, 1'b0, mk(old, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    for (int unsigned i = 0; i < NRST; i++)
      cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, mk(nw, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    for (int unsigned i = 0; i < NSET; i++)
      cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, mk(nw, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, mk(nw, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
    idle(nw, 2'b00);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0)
        chk(tag_q.pop_front(),
            {baud_rate, gen_reset_n, tx_hold, cfg_done, cfg_err, err_cause, cfg_ready},
            exp_q.pop_front());
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
    n_mis++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $fatal(1, "time limit");
  end

  initial begin : stim
    cur_tag = "reset";
    repeat (3) cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, mk(DEF, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    cur_tag = "idle";
    repeat (2) idle(DEF, 2'b00);

    cur_tag = "chg_8";
    change(DEF, 4'b1000, 0);
    idle(4'b1000, 2'b00);

    cur_tag = "drain_wait";
    change(4'b1000, 4'b0110, 50);
    repeat (3) idle(4'b0110, 2'b00);

    cur_tag = "timeout";
    cyc(1'b0, 1'b1, 4'b0101, 1'b0, 1'b1, mk(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    for (int unsigned i = 1; i < NTO; i++)
      cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, mk(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, mk(4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1));
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, mk(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1));
    idle(4'b0110, 2'b10);

    cur_tag = "invalid";
    cyc(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, mk(4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1));
    idle(4'b0110, 2'b01);
    cyc(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, mk(4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1));
    cyc(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, mk(4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1));
    idle(4'b0110, 2'b01);

    cur_tag = "same_code";
    cyc(1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, mk(4'b0110, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
    idle(4'b0110, 2'b00);

    cur_tag = "chg_min";
    change(4'b0110, 4'b0100, 0);

    cur_tag = "rst_settle";
    cyc(1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, mk(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    for (int unsigned i = 0; i < NRST; i++)
      cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, mk(4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    repeat (5)
      cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, mk(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, mk(DEF, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    repeat (20) idle(DEF, 2'b00);

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
